pipe_hazard_ctrl: RTL

Central hazard and PC-sequencing controller for the 5-stage MIPS pipeline. It drives the PC register's PCWrite hold control, the IF/ID write/flush controls, the ID/EX bubble insertion and the next-PC source select. It covers load-use stalls, multi-cycle mul/div busy stalls, EX-resolved branch flushes, ID jumps and exception redirects. It sits between the decode/execute stage signals and the PC / IF/ID / ID/EX pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/hilo_busy_tracker.sv | 45 ++++
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / PC-sequencing controller:
// next-PC source encodings, controller states and the load-use check.
package pipe_ctrl_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;
    localparam logic [1:0] PCSRC_EXC = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MD_WAIT     = 2'd1,
        EXC_HOLD_ST = 2'd2
    } ctrl_state_e;

    // Register $zero never creates a dependency, so a load to it is harmless.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hilo_busy_tracker.sv
// Down-counter tracking the remaining busy cycles of the HI/LO multiply/divide unit.
module hilo_busy_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load_i,
    input  logic clear_i,
    input  logic active_i,
    output logic last_o
);

    localparam int CW = $clog2(MULDIV_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Abort beats reload beats countdown; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CW'(MULDIV_CYCLES - 1);
        end else if (active_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and PC-sequencing controller: stalls, flushes, bubbles and next-PC select
// for the 5-stage pipeline, with mul/div busy tracking and exception hold.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int EXC_HOLD      = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       ID_ReadsHiLo,
    input  logic       ID_Jump,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_Rt,
    input  logic       EX_MulDivStart,
    input  logic       EX_BranchTaken,
    input  logic       ExcReq,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IFIDFlush,
    output logic       IDEXBubble,
    output logic [1:0] PCSrc,
    output logic       MulDivBusy
);

    localparam int HW = (EXC_HOLD < 1) ? 1 : $clog2(EXC_HOLD + 1);

    ctrl_state_e   state_q;
    ctrl_state_e   state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;

    logic md_load_s;
    logic md_clear_s;
    logic md_last_s;
    logic md_busy_s;
    logic lu_s;
    logic md_s;

    hilo_busy_tracker #(
        .MULDIV_CYCLES(MULDIV_CYCLES)
    ) u_hilo_busy (
        .Clk     (Clk),
        .Reset   (Reset),
        .load_i  (md_load_s),
        .clear_i (md_clear_s),
        .active_i(md_busy_s),
        .last_o  (md_last_s)
    );

    assign md_busy_s = (state_q == MD_WAIT);
    assign lu_s      = load_use_hazard(EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt);
    assign md_s      = md_busy_s && ID_ReadsHiLo;

    // Next-state and counter control; an exception aborts any mul/div in flight.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        md_load_s  = 1'b0;
        md_clear_s = 1'b0;
        if (ExcReq) begin
            md_clear_s = 1'b1;
            if (EXC_HOLD > 0) begin
                hold_d  = HW'(EXC_HOLD);
                state_d = EXC_HOLD_ST;
            end else begin
                hold_d  = '0;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (EX_MulDivStart) begin
                        md_load_s = 1'b1;
                        state_d   = MD_WAIT;
                    end else begin
                        state_d = RUN;
                    end
                end
                MD_WAIT: begin
                    if (EX_MulDivStart) begin
                        md_load_s = 1'b1;
                        state_d   = MD_WAIT;
                    end else if (md_last_s) begin
                        state_d = RUN;
                    end else begin
                        state_d = MD_WAIT;
                    end
                end
                EXC_HOLD_ST: begin
                    if (hold_q <= HW'(1)) begin
                        hold_d  = '0;
                        state_d = RUN;
                    end else begin
                        hold_d  = hold_q - HW'(1);
                        state_d = EXC_HOLD_ST;
                    end
                end
                default: begin
                    md_clear_s = 1'b1;
                    hold_d     = '0;
                    state_d    = RUN;
                end
            endcase
        end
    end

    // Controller state and exception hold counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Pipeline controls in priority order; the hold state overrides branch/stall/jump.
    always_comb begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        PCSrc      = PCSRC_SEQ;
        MulDivBusy = md_busy_s;
        if (Reset) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
            MulDivBusy = 1'b0;
        end else if (ExcReq) begin
            PCSrc      = PCSRC_EXC;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (state_q == EXC_HOLD_ST) begin
            PCWrite    = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (EX_BranchTaken) begin
            PCSrc      = PCSRC_BR;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (lu_s || md_s) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (ID_Jump) begin
            PCSrc     = PCSRC_JMP;
            IFIDFlush = 1'b1;
        end else begin
            PCSrc = PCSRC_SEQ;
        end
    end

endmodule
